dla_hld_lsu_unaligned_read_assembler: RTL



---
 rtl/dla_hld_lsu_rd_assembler_pkg.sv | 33 +++
 rtl/dla_hld_lsu_rd_byte_shifter.sv | 38 +++
 rtl/dla_hld_lsu_unaligned_read_assembler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dla_hld_lsu_rd_assembler_pkg.sv
// Shared helpers for the LSU unaligned read assembler.
// Provides span and width helper functions and the section-counter encoding.
package dla_hld_lsu_rd_assembler_pkg;

    // Section counter encoding: which memory word of the kernel word is being consumed.
    localparam logic [1:0] SEC_FIRST  = 2'd0;
    localparam logic [1:0] SEC_SECOND = 2'd1;
    localparam logic [1:0] SEC_THIRD  = 2'd2;

    // Number of memory words touched by a kernel word starting at byte offset.
    function automatic int unsigned calc_span(input int unsigned offset,
                                              input int unsigned mem_bytes,
                                              input int unsigned ker_bytes);
        return (offset + ker_bytes + mem_bytes - 1) / mem_bytes;
    endfunction

    // OFFSET_W helper: byte offset width within one memory word.
    function automatic int unsigned calc_offset_w(input int unsigned mem_bytes);
        return (mem_bytes > 1) ? $clog2(mem_bytes) : 1;
    endfunction

    // SPAN_W helper: wide enough that the span arithmetic never truncates.
    function automatic int unsigned calc_span_w(input int unsigned mem_bytes,
                                                input int unsigned ker_bytes);
        return $clog2(mem_bytes + ker_bytes) + 1;
    endfunction

    // Section counter width, trimmed when fewer than three sections are possible.
    function automatic int unsigned calc_sec_w(input int unsigned max_words);
        return (max_words > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/dla_hld_lsu_rd_byte_shifter.sv
// Combinational byte select of one memory word into kernel-byte lanes.
// Ports:
//   offset     - byte offset of kernel byte 0 within the first memory word
//   sec        - which memory word of the kernel word this is (0..2)
//   mem_data   - memory word, byte 0 in bits [7:0]
//   byte_en_c  - kernel lanes supplied by this memory word
//   ker_data_c - memory bytes moved into their kernel lanes (0 elsewhere)
module dla_hld_lsu_rd_byte_shifter
    import dla_hld_lsu_rd_assembler_pkg::*;
#(
    parameter int unsigned MEM_DATA_BYTES = 64,
    parameter int unsigned KER_DATA_BYTES = 4,
    parameter int unsigned OFFSET_W       = 6,
    parameter int unsigned SEC_W          = 2
) (
    input  logic [OFFSET_W-1:0]         offset,
    input  logic [SEC_W-1:0]            sec,
    input  logic [8*MEM_DATA_BYTES-1:0] mem_data,
    output logic [KER_DATA_BYTES-1:0]   byte_en_c,
    output logic [8*KER_DATA_BYTES-1:0] ker_data_c
);

    // Memory byte index that feeds kernel byte 0 in this section (may be negative).
    int base;

    always_comb begin
        byte_en_c  = '0;
        ker_data_c = '0;
        base       = int'(offset) - int'(sec) * int'(MEM_DATA_BYTES);
        for (int k = 0; k < int'(KER_DATA_BYTES); k++) begin
            if ((base + k) >= 0 && (base + k) < int'(MEM_DATA_BYTES)) begin
                byte_en_c[k]          = 1'b1;
                ker_data_c[8*k +: 8]  = mem_data[8*(base + k) +: 8];
            end
        end
    end

endmodule

// File: rtl/dla_hld_lsu_unaligned_read_assembler.sv
// Read-side unaligned assembler: gathers the 1-3 memory-word sections of each
// kernel word and emits aligned kernel words on a valid/ready interface. The
// head memory word is kept for the next kernel word when the command marks the
// pair as coalesced.
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready - command fifo head (offset, coalesce) and pop
//   i_mem_*/o_mem_ready - memory read-data fifo head and pop
//   o_ker_*/i_ker_ready - registered aligned kernel word output
// Optional: define DLA_HLD_LSU_RD_ASSEMBLER_PERF_COUNTERS_EN to add the
// saturating o_coalesce_count and o_stall_count outputs.
module dla_hld_lsu_unaligned_read_assembler
    import dla_hld_lsu_rd_assembler_pkg::*;
#(
    parameter int unsigned MEM_DATA_BYTES             = 64,
    parameter int unsigned KER_DATA_BYTES             = 4,
    parameter int unsigned MAX_MEM_WORDS_PER_KER_WORD = 3,
    parameter int unsigned ASYNC_RESET                = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                i_cmd_valid,
    input  logic [$clog2(MEM_DATA_BYTES)-1:0]   i_cmd_offset,
    input  logic                                i_cmd_can_coalesce,
    output logic                                o_cmd_ready,
    input  logic                                i_mem_valid,
    input  logic [8*MEM_DATA_BYTES-1:0]         i_mem_data,
    output logic                                o_mem_ready,
    output logic                                o_ker_valid,
    input  logic                                i_ker_ready,
    output logic [8*KER_DATA_BYTES-1:0]         o_ker_data
`ifdef DLA_HLD_LSU_RD_ASSEMBLER_PERF_COUNTERS_EN
    ,
    output logic [31:0]                         o_coalesce_count,
    output logic [31:0]                         o_stall_count
`endif
);

    localparam int unsigned OFFSET_W = calc_offset_w(MEM_DATA_BYTES);
    localparam int unsigned SPAN_W   = calc_span_w(MEM_DATA_BYTES, KER_DATA_BYTES);
    localparam int unsigned SEC_W    = calc_sec_w(MAX_MEM_WORDS_PER_KER_WORD);
    localparam int unsigned KER_W    = 8 * KER_DATA_BYTES;

    // Elaboration-time parameter legality.
    if (ASYNC_RESET != 0) begin : g_err_async
        $error("ASYNC_RESET must be 0");
    end
    if (MEM_DATA_BYTES < 2 || (MEM_DATA_BYTES & (MEM_DATA_BYTES - 1)) != 0) begin : g_err_mem
        $error("MEM_DATA_BYTES must be a power of 2 (>= 2)");
    end
    if (MAX_MEM_WORDS_PER_KER_WORD < 1 || MAX_MEM_WORDS_PER_KER_WORD > 3) begin : g_err_max
        $error("MAX_MEM_WORDS_PER_KER_WORD must be 1..3");
    end
    if (calc_span(MEM_DATA_BYTES - 1, MEM_DATA_BYTES, KER_DATA_BYTES) > MAX_MEM_WORDS_PER_KER_WORD) begin : g_err_span
        $error("worst-case span exceeds MAX_MEM_WORDS_PER_KER_WORD");
    end

    logic [SEC_W-1:0]          sec, sec_nxt;
    logic [KER_W-1:0]          stg, stg_nxt;
    logic                      ker_valid_nxt;
    logic [KER_W-1:0]          ker_data_nxt;
    logic [SPAN_W-1:0]         span;
    logic                      out_space, advance, is_last;
    logic [KER_DATA_BYTES-1:0] sh_en;
    logic [KER_W-1:0]          sh_data, merged;

    assign span      = SPAN_W'(calc_span(32'(i_cmd_offset), MEM_DATA_BYTES, KER_DATA_BYTES));
    assign out_space = ~o_ker_valid | i_ker_ready;
    // Output space gates every section, keeping the staging path free of stall muxing.
    assign advance   = i_cmd_valid & i_mem_valid & out_space;
    assign is_last   = (span == SPAN_W'(sec) + SPAN_W'(1));

    dla_hld_lsu_rd_byte_shifter #(
        .MEM_DATA_BYTES (MEM_DATA_BYTES),
        .KER_DATA_BYTES (KER_DATA_BYTES),
        .OFFSET_W       (OFFSET_W),
        .SEC_W          (SEC_W)
    ) u_shifter (
        .offset     (i_cmd_offset),
        .sec        (sec),
        .mem_data   (i_mem_data),
        .byte_en_c  (sh_en),
        .ker_data_c (sh_data)
    );

    // Overlay this section's bytes on what earlier sections staged.
    always_comb begin
        merged = stg;
        for (int k = 0; k < int'(KER_DATA_BYTES); k++) begin
            if (sh_en[k]) begin
                merged[8*k +: 8] = sh_data[8*k +: 8];
            end
        end
    end

    // Next-state and fifo pop decode.
    always_comb begin
        sec_nxt       = sec;
        stg_nxt       = stg;
        ker_valid_nxt = o_ker_valid & ~i_ker_ready;
        ker_data_nxt  = o_ker_data;
        o_cmd_ready   = 1'b0;
        o_mem_ready   = 1'b0;
        if (advance && !reset) begin
            if (is_last) begin
                ker_data_nxt  = merged;
                ker_valid_nxt = 1'b1;
                sec_nxt       = SEC_W'(SEC_FIRST);
                o_cmd_ready   = 1'b1;
                // A coalesced successor starts in this same memory word.
                o_mem_ready   = ~i_cmd_can_coalesce;
            end else begin
                stg_nxt     = merged;
                sec_nxt     = sec + SEC_W'(1);
                o_mem_ready = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sec         <= SEC_W'(SEC_FIRST);
            stg         <= '0;
            o_ker_valid <= 1'b0;
            o_ker_data  <= '0;
        end else begin
            sec         <= sec_nxt;
            stg         <= stg_nxt;
            o_ker_valid <= ker_valid_nxt;
            o_ker_data  <= ker_data_nxt;
        end
    end

`ifdef DLA_HLD_LSU_RD_ASSEMBLER_PERF_COUNTERS_EN
    logic stall;
    assign stall = i_cmd_valid & i_mem_valid & ~out_space;

    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_coalesce_count <= '0;
            o_stall_count    <= '0;
        end else begin
            if (advance && is_last && i_cmd_can_coalesce && (o_coalesce_count != 32'hFFFF_FFFF)) begin
                o_coalesce_count <= o_coalesce_count + 32'd1;
            end
            if (stall && (o_stall_count != 32'hFFFF_FFFF)) begin
                o_stall_count <= o_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
